// File: rtl/noc_bridge_vc_tx.sv
// noc_bridge_vc_tx: credit-based virtual-channel transmitter for a NoC bridge.
// Three input channels (narrow response, narrow request, wide) share one AXIS
// output. Each channel spends remote credits to send data. Each outgoing beat
// also piggybacks credits for local rx buffer slots that were freed. A beat with
// nothing to send except credits is emitted as a credit-only packet.
//
// Handshake semantics (all valid/ready pairs in this block): a transfer happens
// in a cycle where valid and ready are both high at the rising clock edge. A
// source must hold valid and payload stable until that transfer. The input
// ready_o signals are combinational. They are high only when the output
// register loads and that channel wins arbitration. axis_tvalid_o comes straight
// from the output register and never depends on axis_tready_i.
module noc_bridge_vc_tx #(
  parameter int NumCredNarrowReq = 20,
  parameter int NumCredNarrowRsp = 20,
  parameter int NumCredWide      = 20,
  parameter int NarrowReqW       = 64,
  parameter int NarrowRspW       = 64,
  parameter int WideW            = 128,
  localparam int MaxCredNarrow   = (NumCredNarrowReq > NumCredNarrowRsp) ?
                                   NumCredNarrowReq : NumCredNarrowRsp,
  localparam int MaxCred         = (MaxCredNarrow > NumCredWide) ? MaxCredNarrow : NumCredWide,
  localparam int CredW           = $clog2(MaxCred + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   narrow_req_valid_i,
  output logic                   narrow_req_ready_o,
  input  logic [NarrowReqW-1:0]  narrow_req_data_i,
  input  logic                   narrow_rsp_valid_i,
  output logic                   narrow_rsp_ready_o,
  input  logic [NarrowRspW-1:0]  narrow_rsp_data_i,
  input  logic                   wide_valid_i,
  output logic                   wide_ready_o,
  input  logic [WideW-1:0]       wide_data_i,
  input  logic [2:0]             cred_free_i,
  input  logic                   cred_in_valid_i,
  input  logic [1:0]             cred_in_hdr_i,
  input  logic [CredW-1:0]       cred_in_i,
  output logic                   axis_tvalid_o,
  input  logic                   axis_tready_i,
  output logic [2+WideW-1:0]     axis_tdata_o,
  output logic [1+2+CredW-1:0]   axis_tuser_o
);

  localparam int         NumCh   = 3;
  localparam logic [1:0] HdrRsp  = 2'd0;
  localparam logic [1:0] HdrReq  = 2'd1;
  localparam logic [1:0] HdrWide = 2'd2;
  localparam int         TdataW  = 2 + WideW;
  localparam int         TuserW  = 1 + 2 + CredW;

  // Credit limit of a channel, indexed by its header value.
  function automatic logic [CredW-1:0] cred_max(input logic [1:0] ch);
    case (ch)
      HdrRsp:  cred_max = CredW'(NumCredNarrowRsp);
      HdrReq:  cred_max = CredW'(NumCredNarrowReq);
      default: cred_max = CredW'(NumCredWide);
    endcase
  endfunction

  // Channel k positions after ptr in the cyclic order rsp -> req -> wide -> rsp.
  function automatic logic [1:0] rr_step(input logic [1:0] ptr, input int k);
    int t;
    t = int'(ptr) + k;
    if (t >= NumCh) t = t - NumCh;
    return t[1:0];
  endfunction

  // Registered state
  logic [CredW-1:0]  cred_q [NumCh];
  logic [CredW-1:0]  cred_d [NumCh];
  logic [CredW-1:0]  pend_q [NumCh];
  logic [CredW-1:0]  pend_d [NumCh];
  logic              out_valid_q, out_valid_d;
  logic [TdataW-1:0] out_data_q, out_data_d;
  logic [TuserW-1:0] out_user_q, out_user_d;
  logic [1:0]        data_rr_q, data_rr_d;   // last channel granted data
  logic [1:0]        cred_rr_q, cred_rr_d;   // last channel whose credits were piggybacked

  // Combinational helpers
  logic [2:0]        in_valid;
  logic [2:0]        eligible;
  logic [2:0]        pend_nz;
  logic [1:0]        data_win, cred_win, cand;
  logic              data_found, cred_found;
  logic              load_slot, load;
  logic [2:0]        send, piggy;
  logic [WideW-1:0]  win_data;
  logic [CredW-1:0]  credits_out;
  logic [CredW-1:0]  ret_amt, pend_base;
  logic [CredW:0]    cred_sum, pend_sum;
  logic [2:0]        cred_ovf, pend_ovf;

  assign in_valid = {wide_valid_i, narrow_req_valid_i, narrow_rsp_valid_i};

  // Round-robin searches: data over eligible channels, credits over non-zero pending counts.
  always_comb begin
    eligible   = '0;
    pend_nz    = '0;
    data_win   = HdrRsp;
    data_found = 1'b0;
    cred_win   = HdrRsp;
    cred_found = 1'b0;
    cand       = HdrRsp;
    for (int i = 0; i < NumCh; i++) begin
      eligible[i] = in_valid[i] && (cred_q[i] != '0);
      pend_nz[i]  = (pend_q[i] != '0);
    end
    for (int k = 1; k <= NumCh; k++) begin
      cand = rr_step(data_rr_q, k);
      if (!data_found && eligible[cand]) begin
        data_win   = cand;
        data_found = 1'b1;
      end
    end
    for (int k = 1; k <= NumCh; k++) begin
      cand = rr_step(cred_rr_q, k);
      if (!cred_found && pend_nz[cand]) begin
        cred_win   = cand;
        cred_found = 1'b1;
      end
    end
  end

  // Decide whether the output register loads this cycle and who is served.
  always_comb begin
    load_slot = !out_valid_q || axis_tready_i;
    load      = !rst_i && load_slot && (data_found || cred_found);
    send      = '0;
    piggy     = '0;
    if (load && data_found) send[data_win] = 1'b1;
    if (load && cred_found) piggy[cred_win] = 1'b1;
  end

  assign narrow_rsp_ready_o = send[HdrRsp];
  assign narrow_req_ready_o = send[HdrReq];
  assign wide_ready_o       = send[HdrWide];

  // Select the winning payload, zero-extending narrow flits to the wide width.
  always_comb begin
    win_data = '0;
    case (data_win)
      HdrRsp:  win_data = WideW'(narrow_rsp_data_i);
      HdrReq:  win_data = WideW'(narrow_req_data_i);
      HdrWide: win_data = wide_data_i;
      default: win_data = '0;
    endcase
  end

  // Remote credit and pending-return counters: spend/return and free/piggyback, saturating.
  always_comb begin
    ret_amt   = '0;
    pend_base = '0;
    cred_sum  = '0;
    pend_sum  = '0;
    cred_ovf  = '0;
    pend_ovf  = '0;
    for (int i = 0; i < NumCh; i++) begin
      cred_d[i] = cred_q[i];
      pend_d[i] = pend_q[i];
      ret_amt   = (cred_in_valid_i && (cred_in_hdr_i == 2'(i))) ? cred_in_i : '0;
      cred_sum  = {1'b0, cred_q[i]} + {1'b0, ret_amt} - {{CredW{1'b0}}, send[i]};
      if (cred_sum > {1'b0, cred_max(2'(i))}) begin
        cred_d[i]   = cred_max(2'(i));
        cred_ovf[i] = 1'b1;
      end else begin
        cred_d[i] = cred_sum[CredW-1:0];
      end
      pend_base = piggy[i] ? '0 : pend_q[i];
      pend_sum  = {1'b0, pend_base} + {{CredW{1'b0}}, cred_free_i[i]};
      if (pend_sum > {1'b0, cred_max(2'(i))}) begin
        pend_d[i]   = cred_max(2'(i));
        pend_ovf[i] = 1'b1;
      end else begin
        pend_d[i] = pend_sum[CredW-1:0];
      end
    end
  end

  // Next contents of the one-entry output register and the round-robin pointers.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    data_rr_d   = data_rr_q;
    cred_rr_d   = cred_rr_q;
    credits_out = cred_found ? pend_q[cred_win] : '0;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = data_found ? {data_win, win_data} : '0;
      out_user_d  = {data_found, (cred_found ? cred_win : HdrRsp), credits_out};
      if (data_found) data_rr_d = data_win;
      if (cred_found) cred_rr_d = cred_win;
    end else if (out_valid_q && axis_tready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any held packet and restores full remote credit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCh; i++) begin
        cred_q[i] <= cred_max(2'(i));
        pend_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      data_rr_q   <= HdrWide;
      cred_rr_q   <= HdrWide;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        cred_q[i] <= cred_d[i];
        pend_q[i] <= pend_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      data_rr_q   <= data_rr_d;
      cred_rr_q   <= cred_rr_d;
    end
  end

  // Overflowing credit returns or free pulses mean the link partner broke the protocol.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_cred_ovf: assert (cred_ovf == '0);
      a_pend_ovf: assert (pend_ovf == '0);
    end
  end

  assign axis_tvalid_o = out_valid_q;
  assign axis_tdata_o  = out_data_q;
  assign axis_tuser_o  = out_user_q;

endmodule

// File: doc/noc_bridge_vc_tx.md
NOC_BRIDGE_VC_TX -- requirements
Module: noc_bridge_vc_tx

Interface
REQ-001 SHALL have parameter NumCredNarrowReq, default 20, initial remote credits for the narrow-request channel.
REQ-002 SHALL have parameter NumCredNarrowRsp, default 20, initial remote credits for the narrow-response channel.
REQ-003 SHALL have parameter NumCredWide, default 20, initial remote credits for the wide channel.
REQ-004 SHALL have parameter NarrowReqW / NarrowRspW / WideW, defaults 64 / 64 / 128, flit payload widths without handshake bits; narrow widths ≤ WideW.
REQ-005 SHALL derive CredW = $clog2(max(NumCred*)+1).
REQ-006 SHALL use a single clock and a synchronous, active-high reset.
REQ-007 SHALL have the following ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- narrow_req_valid_i / narrow_req_ready_o / narrow_req_data_i  in/out/in  1/1/NarrowReqW  narrow-request flit input
- narrow_rsp_valid_i / narrow_rsp_ready_o / narrow_rsp_data_i  in/out/in  1/1/NarrowRspW  narrow-response flit input
- wide_valid_i / wide_ready_o / wide_data_i  in/out/in  1/1/WideW  wide flit input
- cred_free_i  in  3  one pulse per local rx buffer slot freed; bit0 rsp, bit1 req, bit2 wide
- cred_in_valid_i  in  1  remote credit return decoded by local rx
- cred_in_hdr_i  in  2  channel of the returned credits
- cred_in_i  in  CredW  number of credits returned
- axis_tvalid_o / axis_tready_i  out/in  1/1  AXIS handshake
- axis_tdata_o  out  2+WideW  {data_hdr, data}
- axis_tuser_o  out  1+2+CredW  {data_validity, credits_hdr, credits}

Function
REQ-008 The header encoding SHALL be: narrow_response=0, narrow_request=1, wide=2. Value 3 SHALL never be emitted. cred_in with hdr 3 SHALL be ignored.
REQ-009 Each channel SHALL keep a remote credit counter. A channel is eligible when its valid is high and its credit counter is >0.
REQ-010 Send credits SHALL update in one cycle as credit_next = credit - (flit accepted on ch) + (cred_in_valid_i && hdr==ch ? cred_in_i : 0). A simultaneous send and return SHALL both apply.
REQ-011 A remote credit counter SHALL never exceed its NumCred. An overflowing return is an error, flagged by assertion, with the counter saturating at NumCred.
REQ-012 The block SHALL have a one-entry output register. The register loads when empty, or when axis_tvalid_o && axis_tready_i in the same cycle, giving full throughput.
REQ-013 While axis_tvalid_o is high and axis_tready_i is low, axis_tdata_o and axis_tuser_o SHALL hold stable.
REQ-014 Data arbitration SHALL be round-robin over eligible channels. The search starts after the last granted channel in order rsp→req→wide→rsp.
REQ-015 A channel's ready_o SHALL be high only in a cycle where the output register loads and that channel wins. At most one ready_o SHALL be high per cycle.
REQ-016 Latency: an input handshake in cycle N SHALL produce axis_tvalid_o=1 with that flit in cycle N+1.
REQ-017 A data packet SHALL carry data_validity=1 and data_hdr=channel. Narrow payloads SHALL be zero-extended to WideW.
REQ-018 Each channel SHALL keep a pending-return counter (width CredW), updated as pending_next = pending - (credits piggybacked for ch) + cred_free_i[ch].
REQ-019 Every loaded packet SHALL piggyback credits:
- credits_hdr = next channel with pending>0, by a separate round-robin pointer
- credits = that channel's full pending value
- if all pending counts are 0: credits=0, credits_hdr=0
REQ-020 When no channel is eligible and any pending>0, the register SHALL load a credit-only packet: data_validity=0, data_hdr=0, data=0.
REQ-021 When no channel is eligible and all pending counts are 0, the register SHALL NOT load, and axis_tvalid_o falls after the drain.
REQ-022 Pending counters SHALL never exceed their channel NumCred. This is asserted.

Reset
REQ-023 While rst_i is high at a clock edge, the block SHALL set:
- remote credit counters to NumCred*
- pending counters to 0
- axis_tvalid_o=0, axis_tdata_o=0, axis_tuser_o=0
- all ready_o=0
- both round-robin pointers so that rsp is searched first
REQ-024 A reset asserted mid-operation SHALL discard any held output packet without completing the handshake.

Verification
REQ-025 After reset, wide_valid_i=1 continuously with axis_tready_i=1 and no returns → exactly 20 packets with hdr=2 are sent, then wide_ready_o stays 0. One return of hdr=2, cred_in_i=1 → exactly one more is sent.
REQ-026 All three channels valid, tready=1 → the data_hdr sequence is 0,1,2,0,1,2 with one packet per cycle.
REQ-027 axis_tready_i held 0 for 5 cycles with narrow_req valid → tdata/tuser are stable and only the first flit is accepted. On release, the next flit follows with no bubble.
REQ-028 Inputs idle, cred_free_i[2] pulsed 3 times → one credit-only packet with validity=0, credits_hdr=2, credits=3 (or split across consecutive packets, with the sum equal to 3).
REQ-029 A cred_free_i pulse in the same cycle a packet piggybacks that channel's pending value of 4 → pending becomes 1.
REQ-030 rst_i asserted while axis_tvalid_o=1 and tready=0 → the next cycle has tvalid=0 and all credit counters equal to 20.
